// File: rtl/lv1a_gen.sv
// Level-1 trigger gate: live gating, per-bit prescale and dead-time enforcement.
// All outputs are registered one cycle after the inputs they reflect.
module lv1a_gen #(
  parameter int NTRIG  = 8,
  parameter int PS_W   = 8,
  parameter int DEAD_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_live,
  input  logic [NTRIG-1:0]      in_trig,
  input  logic [3:0]            in_ext,
  input  logic                  in_delta,
  input  logic [NTRIG*PS_W-1:0] cfg_ps,
  input  logic [DEAD_W-1:0]     cfg_dead,
  output logic [NTRIG-1:0]      out_lv1a_raw,
  output logic [NTRIG-1:0]      out_lv1a,
  output logic [3:0]            out_ext,
  output logic                  out_delta,
  output logic                  out_accept,
  output logic                  out_busy
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [DEAD_W-1:0] DEAD_ONE = DEAD_W'(1);
  localparam logic [PS_W:0]     INC_ONE  = (PS_W+1)'(1);

  state_e              state_q, state_d;
  logic [DEAD_W-1:0]   dcnt_q, dcnt_d;
  logic [PS_W-1:0]     cnt_q [NTRIG];
  logic [PS_W-1:0]     cnt_d [NTRIG];
  logic                pre_live_q, pre_live_d;
  logic                live_rise;
  logic [NTRIG-1:0]    pass;
  logic [PS_W-1:0]     base;
  logic [PS_W-1:0]     ps_i;
  logic [PS_W:0]       inc;

  logic [NTRIG-1:0]    lv1a_raw_q, lv1a_raw_d;
  logic [NTRIG-1:0]    lv1a_q, lv1a_d;
  logic [3:0]          ext_q, ext_d;
  logic                delta_q, delta_d;
  logic                accept_q, accept_d;
  logic                busy_q, busy_d;

  assign live_rise  = in_live & ~pre_live_q;
  assign pre_live_d = in_live;

  // Counters clear on live rise before this cycle's pulse is counted;
  // the >= test lets a lowered prescale fire on the next pulse without wrapping.
  always_comb begin
    base = '0;
    ps_i = '0;
    inc  = '0;
    pass = '0;
    for (int unsigned i = 0; i < NTRIG; i++) begin
      base     = live_rise ? '0 : cnt_q[i];
      ps_i     = cfg_ps[i*PS_W +: PS_W];
      inc      = {1'b0, base} + INC_ONE;
      cnt_d[i] = base;
      if (ps_i == '0) begin
        cnt_d[i] = '0;
      end else if (state_q == IDLE && in_live && in_trig[i]) begin
        if (inc >= {1'b0, ps_i}) begin
          pass[i]  = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = inc[PS_W-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (accept_d && cfg_dead != '0) begin
          state_d = BUSY;
          dcnt_d  = cfg_dead;
        end
      end
      BUSY: begin
        dcnt_d = dcnt_q - DEAD_ONE;
        if (dcnt_q == DEAD_ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lv1a_raw_d = in_live ? in_trig : '0;
    lv1a_d     = '0;
    ext_d      = '0;
    delta_d    = 1'b0;
    if (state_q == IDLE) begin
      lv1a_d  = pass;
      ext_d   = in_live ? in_ext : '0;
      delta_d = in_live & in_delta;
    end
    accept_d = (|lv1a_d) | (|ext_d) | delta_d;
    busy_d   = (state_q == BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dcnt_q     <= '0;
      pre_live_q <= 1'b0;
      for (int unsigned i = 0; i < NTRIG; i++) cnt_q[i] <= '0;
      lv1a_raw_q <= '0;
      lv1a_q     <= '0;
      ext_q      <= '0;
      delta_q    <= 1'b0;
      accept_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      pre_live_q <= pre_live_d;
      for (int unsigned i = 0; i < NTRIG; i++) cnt_q[i] <= cnt_d[i];
      lv1a_raw_q <= lv1a_raw_d;
      lv1a_q     <= lv1a_d;
      ext_q      <= ext_d;
      delta_q    <= delta_d;
      accept_q   <= accept_d;
      busy_q     <= busy_d;
    end
  end

  assign out_lv1a_raw = lv1a_raw_q;
  assign out_lv1a     = lv1a_q;
  assign out_ext      = ext_q;
  assign out_delta    = delta_q;
  assign out_accept   = accept_q;
  assign out_busy     = busy_q;

endmodule

// File: tb/tb_lv1a_gen.sv
// Scoreboarded bench for lv1a_gen: a cycle-level reference model pushes expected
// outputs at stimulus time; a monitor pops and compares one cycle later.
module tb_lv1a_gen;

  logic        clk;
  logic        reset;
  logic        in_live;
  logic [7:0]  in_trig;
  logic [3:0]  in_ext;
  logic        in_delta;
  logic [63:0] cfg_ps;
  logic [7:0]  cfg_dead;
  logic [7:0]  out_lv1a_raw;
  logic [7:0]  out_lv1a;
  logic [3:0]  out_ext;
  logic        out_delta;
  logic        out_accept;
  logic        out_busy;

  lv1a_gen #(.NTRIG(8), .PS_W(8), .DEAD_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_live      (in_live),
    .in_trig      (in_trig),
    .in_ext       (in_ext),
    .in_delta     (in_delta),
    .cfg_ps       (cfg_ps),
    .cfg_dead     (cfg_dead),
    .out_lv1a_raw (out_lv1a_raw),
    .out_lv1a     (out_lv1a),
    .out_ext      (out_ext),
    .out_delta    (out_delta),
    .out_accept   (out_accept),
    .out_busy     (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] lv1a;
    logic [3:0] ext;
    logic       delta;
    logic       accept;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Staged configuration, applied to the DUT together with the next stimulus.
  int unsigned ps_n[8];
  int unsigned dead_n;

  // Reference model state.
  int unsigned m_cnt[8];
  int unsigned m_dead_left;
  bit          m_prev_live;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_cycle();
    exp_t x;
    bit   busy_now;
    x.raw = 8'h00; x.lv1a = 8'h00; x.ext = 4'h0;
    x.delta = 1'b0; x.accept = 1'b0; x.busy = 1'b0;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_dead_left = 0;
      m_prev_live = 0;
    end else begin
      busy_now = (m_dead_left > 0);
      x.raw    = in_live ? in_trig : 8'h00;
      x.busy   = busy_now;
      if (in_live && !m_prev_live)
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      for (int i = 0; i < 8; i++) begin
        if (ps_n[i] == 0) begin
          m_cnt[i] = 0;
        end else if (!busy_now && in_live && in_trig[i]) begin
          if (m_cnt[i] + 1 >= ps_n[i]) begin
            x.lv1a[i] = 1'b1;
            m_cnt[i]  = 0;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
      if (busy_now) begin
        m_dead_left = m_dead_left - 1;
      end else begin
        x.ext    = in_live ? in_ext : 4'h0;
        x.delta  = in_live & in_delta;
        x.accept = (x.lv1a != 0) || (x.ext != 0) || x.delta;
        if (x.accept && dead_n != 0) m_dead_left = dead_n;
      end
      m_prev_live = in_live;
    end
    exp_q.push_back(x);
  endtask

  task automatic step(input logic r, input logic l, input logic [7:0] t,
                      input logic [3:0] e, input logic d);
    @(negedge clk);
    reset    = r;
    in_live  = l;
    in_trig  = t;
    in_ext   = e;
    in_delta = d;
    for (int i = 0; i < 8; i++) cfg_ps[i*8 +: 8] = ps_n[i][7:0];
    cfg_dead = dead_n[7:0];
    model_cycle();
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("raw",    int'(out_lv1a_raw), int'(x.raw));
        chk("lv1a",   int'(out_lv1a),     int'(x.lv1a));
        chk("ext",    int'(out_ext),      int'(x.ext));
        chk("delta",  int'(out_delta),    int'(x.delta));
        chk("accept", int'(out_accept),   int'(x.accept));
        chk("busy",   int'(out_busy),     int'(x.busy));
      end
    end
  end

  initial begin : stimulus
    logic       l;
    logic       r;
    reset = 1'b1; in_live = 1'b1; in_trig = 8'hFF; in_ext = 4'h0; in_delta = 1'b0;
    cfg_ps = '0; cfg_dead = '0;
    for (int i = 0; i < 8; i++) ps_n[i] = 0;
    dead_n = 0;

    // Reset with triggers present, then raw passes on release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'hFF, 4'h0, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 4'h0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);

    // Prescale 1 on bit 0, no dead time.
    ps_n[0] = 1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h01, 4'h0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 4'h0, 1'b0);

    // Prescale 4 on bit 3.
    ps_n[0] = 0; ps_n[3] = 4;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'h08, 4'h0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 4'h0, 1'b0);
    end

    // Dead time 5 with bit 0 held high.
    ps_n[3] = 0; ps_n[0] = 1; dead_n = 5;
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 8'h01, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'h00, 4'h0, 1'b0);

    // Live rise clears the prescale count.
    ps_n[0] = 0; ps_n[1] = 3; dead_n = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 8'h02, 4'h0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 4'h0, 1'b0);
    end
    step(1'b0, 1'b0, 8'h02, 4'h0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h02, 4'h0, 1'b0);
      step(1'b0, 1'b1, 8'h00, 4'h0, 1'b0);
    end

    // Disabled bit, ext accept, reset during busy.
    ps_n[1] = 0; ps_n[2] = 0; dead_n = 4;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h04, 4'h0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 4'h2, 1'b0);
    step(1'b0, 1'b1, 8'h00, 4'h0, 1'b0);
    step(1'b1, 1'b1, 8'h00, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 4'h0, 1'b1);

    // Randomized traffic.
    l = 1'b1;
    for (int i = 0; i < 8; i++) ps_n[i] = $urandom_range(0, 5);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) l = ~l;
      if ($urandom_range(0, 49) == 0) ps_n[$urandom_range(0, 7)] = $urandom_range(0, 5);
      if ($urandom_range(0, 29) == 0) dead_n = $urandom_range(0, 6);
      r = ($urandom_range(0, 149) == 0);
      step(r, l, 8'($urandom) & 8'($urandom),
           ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0,
           ($urandom_range(0, 9) == 0));
    end

    step(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
